// File: rtl/d_latch.sv
// Gated level-sensitive D latch with active-low asynchronous clear.
// Transparent while g_i=1, holds while g_i=0.
module d_latch (
    input  logic g_i,
    input  logic clrn_i,
    input  logic d_i,
    output logic q_o
);

    always_latch begin
        if (!clrn_i) begin
            q_o <= 1'b0;
        end else if (g_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/d_ff_ec.sv
// Rising-edge D flip-flop with capture enable and asynchronous active-low clear.
// Each bit is a master-slave latch pair; the enable recirculates Q rather than gating the clock.
module d_ff_ec #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic [WIDTH-1:0] D,
    input  logic             En,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    logic clk_n;

    assign clk_n = ~Clk;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic mux_d;
        logic master_q;

        // Hold is a recirculation of the stored bit into the master.
        assign mux_d = En ? D[i] : Q[i];

        d_latch u_master (
            .g_i   (clk_n),
            .clrn_i(Clrn),
            .d_i   (mux_d),
            .q_o   (master_q)
        );

        d_latch u_slave (
            .g_i   (Clk),
            .clrn_i(Clrn),
            .d_i   (master_q),
            .q_o   (Q[i])
        );
    end

    assign Qn = ~Q;

endmodule

// File: tb/tb_d_ff_ec.sv
// Directed bench for d_ff_ec: a 1-bit and an 8-bit instance run side by side
// on a shared 60 ns clock (rising edges at 30, 90, 150, ... ns).
`timescale 1ns/1ps
module tb_d_ff_ec;

    logic       Clk = 1'b0;

    logic       Clrn1 = 1'b1;
    logic       D1    = 1'b0;
    logic       En1   = 1'b0;
    logic       Q1;
    logic       Qn1;

    logic       Clrn8 = 1'b0;
    logic [7:0] D8    = 8'h00;
    logic       En8   = 1'b0;
    logic [7:0] Q8;
    logic [7:0] Qn8;

    int n_checks = 0;
    int n_errors = 0;

    always #30 Clk = ~Clk;

    d_ff_ec #(.WIDTH(1)) u_dut1 (
        .Clk (Clk),
        .Clrn(Clrn1),
        .D   (D1),
        .En  (En1),
        .Q   (Q1),
        .Qn  (Qn1)
    );

    d_ff_ec #(.WIDTH(8)) u_dut8 (
        .Clk (Clk),
        .Clrn(Clrn8),
        .D   (D8),
        .En  (En8),
        .Q   (Q8),
        .Qn  (Qn8)
    );

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic wait_until(input longint unsigned t);
        if (64'($time) < t) #(t - 64'($time));
    endtask

    initial begin
        fork
            // 1-bit instance
            begin
                D1 = 1'b1; En1 = 1'b1; Clrn1 = 1'b1;
                wait_until(31);
                check("w1_cap_q",  8'(Q1),  8'h01);
                check("w1_cap_qn", 8'(Qn1), 8'h00);
                wait_until(40);  D1 = 1'b0;
                wait_until(89);
                check("w1_no_early_q", 8'(Q1), 8'h01);
                wait_until(91);
                check("w1_cap0_q",  8'(Q1),  8'h00);
                check("w1_cap0_qn", 8'(Qn1), 8'h01);
                wait_until(100); D1 = 1'b1;
                wait_until(151);
                check("w1_cap1_q", 8'(Q1), 8'h01);
                // hold with En=0 while D toggles across three edges
                wait_until(160); En1 = 1'b0; D1 = 1'b0;
                wait_until(211);
                check("w1_hold_e1", 8'(Q1), 8'h01);
                wait_until(220); D1 = 1'b1;
                wait_until(271);
                check("w1_hold_e2", 8'(Q1), 8'h01);
                wait_until(280); D1 = 1'b0;
                wait_until(331);
                check("w1_hold_e3", 8'(Q1), 8'h01);
                // mid-cycle clear, held across edges with D=1, En=1
                wait_until(340); D1 = 1'b1; En1 = 1'b1; Clrn1 = 1'b0;
                #0.5;
                check("w1_clr_q",  8'(Q1),  8'h00);
                check("w1_clr_qn", 8'(Qn1), 8'h01);
                wait_until(391);
                check("w1_clr_edge1", 8'(Q1), 8'h00);
                wait_until(451);
                check("w1_clr_edge2", 8'(Q1), 8'h00);
                wait_until(460); Clrn1 = 1'b1;
                wait_until(461);
                check("w1_rel_q", 8'(Q1), 8'h00);
                wait_until(509);
                check("w1_rel_wait", 8'(Q1), 8'h00);
                wait_until(511);
                check("w1_rel_cap_q",  8'(Q1),  8'h01);
                check("w1_rel_cap_qn", 8'(Qn1), 8'h00);
                // D change between edges has no effect until the edge
                wait_until(520); D1 = 1'b0;
                wait_until(521);
                check("w1_mid_d", 8'(Q1), 8'h01);
                wait_until(571);
                check("w1_mid_d_edge", 8'(Q1), 8'h00);
            end
            // 8-bit instance
            begin
                Clrn8 = 1'b0; D8 = 8'hA5; En8 = 1'b1;
                wait_until(1);
                check("w8_rst_q",  Q8,  8'h00);
                check("w8_rst_qn", Qn8, 8'hFF);
                wait_until(10); Clrn8 = 1'b1;
                wait_until(31);
                check("w8_a5_q",  Q8,  8'hA5);
                check("w8_a5_qn", Qn8, 8'h5A);
                wait_until(40); D8 = 8'h3C; En8 = 1'b0;
                wait_until(91);
                check("w8_hold_q",  Q8,  8'hA5);
                check("w8_hold_qn", Qn8, 8'h5A);
                wait_until(100); En8 = 1'b1;
                wait_until(151);
                check("w8_3c_q",  Q8,  8'h3C);
                check("w8_3c_qn", Qn8, 8'hC3);
                wait_until(160); Clrn8 = 1'b0;
                wait_until(161);
                check("w8_clr_q",  Q8,  8'h00);
                check("w8_clr_qn", Qn8, 8'hFF);
                wait_until(211);
                check("w8_clr_edge", Q8, 8'h00);
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
